multicycle_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the RV32I core. It walks each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the 3-bit `data_control` select of the ALU operand mux. It also drives the memory request handshake and the PC, IR, MDR and register-file write strobes, and keeps a retired-instruction counter. It sits between the instruction register/decoder and the shared datapath: operand mux, ALU, comparator and a single memory port.

---
 rtl/multicycle_ctrl_fsm_pkg.sv | 56 +++++
 rtl/multicycle_ctrl_fsm_inst_classify.sv | 28 ++
 rtl/multicycle_ctrl_fsm.sv | 151 +++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types and constants for the multi-cycle RV32I control sequencer.
package ctrl_pkg;

    localparam int unsigned OPC_W = 7;
    localparam int unsigned DC_W  = 3;

    typedef enum logic [3:0] {
        RST,
        FETCH,
        DECODE,
        EXEC,
        BTGT,
        MEM,
        LDWB,
        WB,
        HALT
    } ctrl_state_e;

    typedef enum logic [3:0] {
        CL_OP,
        CL_OP_IMM,
        CL_LUI,
        CL_AUIPC,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JAL,
        CL_JALR,
        CL_SYSTEM,
        CL_ILLEGAL
    } inst_class_e;

    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [DC_W-1:0] DC_RS1_IMM  = 3'd0;
    localparam logic [DC_W-1:0] DC_PC_IMM   = 3'd1;
    localparam logic [DC_W-1:0] DC_MEM_ZERO = 3'd2;
    localparam logic [DC_W-1:0] DC_RS1_RS2  = 3'd3;

    // inst[31:7] of ebreak; every other SYSTEM encoding is treated as illegal
    localparam logic [24:0] EBREAK_HI = 25'h0002000;

    function automatic logic is_jump(input inst_class_e cls);
        return (cls == CL_JAL) || (cls == CL_JALR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_inst_classify.sv
// Combinational opcode-to-class decode with illegal-opcode flag.
module inst_classify
    import ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output inst_class_e      cls_o,
    output logic             illegal_o
);

    always_comb begin
        cls_o = CL_ILLEGAL;
        case (opcode_i)
            OPC_OP:     cls_o = CL_OP;
            OPC_OP_IMM: cls_o = CL_OP_IMM;
            OPC_LUI:    cls_o = CL_LUI;
            OPC_AUIPC:  cls_o = CL_AUIPC;
            OPC_LOAD:   cls_o = CL_LOAD;
            OPC_STORE:  cls_o = CL_STORE;
            OPC_BRANCH: cls_o = CL_BRANCH;
            OPC_JAL:    cls_o = CL_JAL;
            OPC_JALR:   cls_o = CL_JALR;
            OPC_SYSTEM: cls_o = CL_SYSTEM;
            default:    cls_o = CL_ILLEGAL;
        endcase
        illegal_o = (cls_o == CL_ILLEGAL);
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB walk, datapath
// strobes, memory handshake and retired-instruction counter.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int unsigned INSTRET_W = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          inst,
    input  logic                 branch_taken,
    input  logic                 mem_ack,
    output logic                 mem_req,
    output logic                 mem_fetch,
    output logic                 mem_wen,
    output logic                 ir_write,
    output logic                 mdr_write,
    output logic                 alu_out_write,
    output logic [DC_W-1:0]      data_control,
    output logic                 reg_write,
    output logic                 wb_sel,
    output logic                 pc_write,
    output logic                 pc_src,
    output logic                 halted,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    ctrl_state_e          state_q, state_d;
    logic                 br_t_q, br_t_d;
    logic                 illegal_q, illegal_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;

    inst_class_e cls;
    logic        cls_illegal;

    inst_classify u_classify (
        .opcode_i  (inst[OPC_W-1:0]),
        .cls_o     (cls),
        .illegal_o (cls_illegal)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= RST;
            br_t_q    <= 1'b0;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            br_t_q    <= br_t_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        br_t_d        = br_t_q;
        illegal_d     = illegal_q;
        instret_d     = instret_q;
        mem_req       = 1'b0;
        mem_fetch     = 1'b0;
        mem_wen       = 1'b0;
        ir_write      = 1'b0;
        mdr_write     = 1'b0;
        alu_out_write = 1'b0;
        data_control  = DC_RS1_IMM;
        reg_write     = 1'b0;
        wb_sel        = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        halted        = 1'b0;

        case (state_q)
            RST: state_d = FETCH;

            FETCH: begin
                mem_req   = 1'b1;
                mem_fetch = 1'b1;
                ir_write  = mem_ack;
                if (mem_ack) state_d = DECODE;
            end

            DECODE: begin
                if (cls_illegal) begin
                    state_d   = HALT;
                    illegal_d = 1'b1;
                end else if (cls == CL_SYSTEM) begin
                    state_d = HALT;
                    if (inst[31:7] != EBREAK_HI) illegal_d = 1'b1;
                end else begin
                    state_d = EXEC;
                end
            end

            EXEC: begin
                alu_out_write = 1'b1;
                case (cls)
                    CL_OP:             data_control = DC_RS1_RS2;
                    CL_BRANCH: begin
                        data_control = DC_RS1_RS2;
                        br_t_d       = branch_taken;
                    end
                    CL_AUIPC, CL_JAL:  data_control = DC_PC_IMM;
                    default:           data_control = DC_RS1_IMM;
                endcase
                if (cls == CL_LOAD || cls == CL_STORE) state_d = MEM;
                else if (cls == CL_BRANCH)             state_d = BTGT;
                else                                   state_d = WB;
            end

            // second ALU pass forms the branch target pc+imm
            BTGT: begin
                alu_out_write = 1'b1;
                data_control  = DC_PC_IMM;
                state_d       = WB;
            end

            MEM: begin
                mem_req   = 1'b1;
                mem_wen   = (cls == CL_STORE);
                mdr_write = (cls == CL_LOAD) && mem_ack;
                if (mem_ack) state_d = (cls == CL_LOAD) ? LDWB : WB;
            end

            LDWB: begin
                alu_out_write = 1'b1;
                data_control  = DC_MEM_ZERO;
                state_d       = WB;
            end

            WB: begin
                pc_write  = 1'b1;
                reg_write = (cls != CL_STORE) && (cls != CL_BRANCH);
                wb_sel    = is_jump(cls);
                pc_src    = is_jump(cls) || ((cls == CL_BRANCH) && br_t_q);
                instret_d = instret_q + INSTRET_W'(1);
                state_d   = FETCH;
            end

            HALT: halted = 1'b1;

            default: state_d = RST;
        endcase
    end

    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed + randomized bench for multicycle_ctrl_fsm against a per-instruction phase model.
module tb_multicycle_ctrl_fsm;

    localparam int unsigned IW = 4;

    localparam logic [6:0] O_OP     = 7'b0110011;
    localparam logic [6:0] O_OPIMM  = 7'b0010011;
    localparam logic [6:0] O_LUI    = 7'b0110111;
    localparam logic [6:0] O_AUIPC  = 7'b0010111;
    localparam logic [6:0] O_LOAD   = 7'b0000011;
    localparam logic [6:0] O_STORE  = 7'b0100011;
    localparam logic [6:0] O_BRANCH = 7'b1100011;
    localparam logic [6:0] O_JAL    = 7'b1101111;
    localparam logic [6:0] O_JALR   = 7'b1100111;

    typedef struct packed {
        logic       req, fet, wen, irw, mdrw, alu;
        logic [2:0] dc;
        logic       rw, wbs, pcw, pcs, hlt, ill;
    } obs_t;

    logic          clock, reset, branch_taken, mem_ack;
    logic [31:0]   inst;
    logic          mem_req, mem_fetch, mem_wen, ir_write, mdr_write, alu_out_write;
    logic [2:0]    data_control;
    logic          reg_write, wb_sel, pc_write, pc_src, halted, illegal;
    logic [IW-1:0] instret;
    obs_t          obs;

    int errors = 0;
    int checks = 0;
    int model_instret = 0;

    multicycle_ctrl_fsm #(.INSTRET_W(IW)) dut (
        .clock         (clock),
        .reset         (reset),
        .inst          (inst),
        .branch_taken  (branch_taken),
        .mem_ack       (mem_ack),
        .mem_req       (mem_req),
        .mem_fetch     (mem_fetch),
        .mem_wen       (mem_wen),
        .ir_write      (ir_write),
        .mdr_write     (mdr_write),
        .alu_out_write (alu_out_write),
        .data_control  (data_control),
        .reg_write     (reg_write),
        .wb_sel        (wb_sel),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .halted        (halted),
        .illegal       (illegal),
        .instret       (instret)
    );

    assign obs = {mem_req, mem_fetch, mem_wen, ir_write, mdr_write, alu_out_write,
                  data_control, reg_write, wb_sel, pc_write, pc_src, halted, illegal};

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Drive one cycle of inputs, compare outputs at the falling edge, then advance.
    task automatic cyc(input string tag, input obs_t e, input logic ack,
                       input logic [31:0] iw, input logic bt);
        mem_ack      = ack;
        inst         = iw;
        branch_taken = bt;
        @(negedge clock);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, e);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic check_instret(input string tag);
        checks++;
        assert (instret === IW'(model_instret)) else begin
            errors++;
            $error("FAIL %s instret obs=%0d exp=%0d", tag, instret, IW'(model_instret));
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        mem_ack = rb();
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_instret = 0;
        check_instret("rst_instret");
        cyc("rst", '0, rb(), $urandom, rb());
    endtask

    task automatic fetch_phase(input string tag, input int fw);
        obs_t e;
        for (int i = 0; i <= fw; i++) begin
            e = '0; e.req = 1'b1; e.fet = 1'b1; e.irw = (i == fw);
            cyc({tag, "/fetch"}, e, (i == fw), $urandom, rb());
        end
    endtask

    // One full instruction from FETCH through WB, expectations from the class rules.
    task automatic run_instr(input string tag, input logic [31:0] iw, input int fw,
                             input int mw, input logic bt);
        obs_t       e;
        logic [6:0] op;
        logic       ld, st, br, jmp;
        op  = iw[6:0];
        ld  = (op == O_LOAD);
        st  = (op == O_STORE);
        br  = (op == O_BRANCH);
        jmp = (op == O_JAL) || (op == O_JALR);
        fetch_phase(tag, fw);
        cyc({tag, "/decode"}, '0, rb(), iw, rb());
        e = '0; e.alu = 1'b1;
        e.dc = (op == O_OP || br) ? 3'd3 : (op == O_AUIPC || op == O_JAL) ? 3'd1 : 3'd0;
        cyc({tag, "/exec"}, e, rb(), iw, bt);
        if (br) begin
            e = '0; e.alu = 1'b1; e.dc = 3'd1;
            cyc({tag, "/btgt"}, e, rb(), iw, rb());
        end
        if (ld || st) begin
            for (int j = 0; j <= mw; j++) begin
                e = '0; e.req = 1'b1; e.wen = st; e.mdrw = ld && (j == mw);
                cyc({tag, "/mem"}, e, (j == mw), iw, rb());
            end
        end
        if (ld) begin
            e = '0; e.alu = 1'b1; e.dc = 3'd2;
            cyc({tag, "/ldwb"}, e, rb(), iw, rb());
        end
        e = '0; e.pcw = 1'b1; e.rw = !(st || br); e.wbs = jmp; e.pcs = jmp || (br && bt);
        cyc({tag, "/wb"}, e, rb(), iw, rb());
        model_instret++;
        check_instret({tag, "/instret"});
    endtask

    task automatic run_halt(input string tag, input logic [31:0] iw, input logic ill);
        obs_t e;
        fetch_phase(tag, 0);
        cyc({tag, "/decode"}, '0, rb(), iw, rb());
        for (int k = 0; k < 4; k++) begin
            e = '0; e.hlt = 1'b1; e.ill = ill;
            cyc({tag, "/halt"}, e, 1'b1, iw, rb());
        end
        check_instret({tag, "/instret"});
    endtask

    initial begin
        logic [6:0]  ops [9];
        logic [31:0] r;
        obs_t        e;
        ops = '{O_OP, O_OPIMM, O_LUI, O_AUIPC, O_LOAD, O_STORE, O_BRANCH, O_JAL, O_JALR};
        clock = 1'b0; reset = 1'b1; mem_ack = 1'b0; inst = '0; branch_taken = 1'b0;

        do_reset();
        run_instr("addi", 32'h00500093, 0, 0, 1'b0);
        run_instr("lw", 32'h0000a103, 0, 3, 1'b0);
        run_instr("beq_t", 32'h00000063, 0, 0, 1'b1);
        run_instr("beq_n", 32'h00000063, 0, 0, 1'b0);
        run_instr("jal", 32'h0080006f, 0, 0, 1'b0);

        // random mix; 4-bit counter wraps several times
        for (int n = 0; n < 60; n++) begin
            r = $urandom;
            run_instr("rnd", {r[31:7], ops[$urandom_range(0, 8)]},
                      $urandom_range(0, 2), $urandom_range(0, 2), rb());
        end

        // reset while a store waits for ack
        do_reset();
        run_instr("addi2", 32'h00500093, 1, 0, 1'b0);
        fetch_phase("sw_abort", 0);
        cyc("sw_abort/decode", '0, rb(), 32'h0020a023, rb());
        e = '0; e.alu = 1'b1;
        cyc("sw_abort/exec", e, rb(), 32'h0020a023, rb());
        e = '0; e.req = 1'b1; e.wen = 1'b1;
        cyc("sw_abort/mem", e, 1'b0, 32'h0020a023, rb());
        reset = 1'b1;
        cyc("sw_abort/mem_rst", e, 1'b0, 32'h0020a023, rb());
        reset = 1'b0;
        model_instret = 0;
        check_instret("sw_abort/instret");
        cyc("sw_abort/rst", '0, rb(), 32'h0020a023, rb());
        run_instr("after_abort", 32'h00500093, 0, 0, 1'b0);

        run_halt("illegal", 32'h00000000, 1'b1);
        do_reset();
        run_halt("ebreak", 32'h00100073, 1'b0);
        do_reset();
        run_halt("ecall", 32'h00000073, 1'b1);
        do_reset();
        run_instr("recover", 32'h00500093, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
